flags_ctx_stack: RTL and testbench

- Saves and restores the ALU condition flags (O|S|Z|C) across trap entry and return-from-exception.
- On a trap it captures the ALU's live `flags` output into a LIFO.
- On `rfe` it pops the saved entry and drives it back into the ALU's `flags_restore`/`flags_we` port. It holds `flags_we` until the ALU actually accepts the write.
- Sits beside the ALU in the execute stage and is controlled by the trap/return logic.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/lifo_regfile.sv | 35 +++
 rtl/flags_ctx_stack.sv | 145 ++++++++++++++
 tb/tb_flags_ctx_stack.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: flag vector width, flag bit positions, and the
// state encoding of the flag-context save/restore controller.
// Imported by flags_ctx_stack and lifo_regfile.
package cpu_pkg;

    localparam int FLAG_W = 4;

    // Flag bit positions within the {O,S,Z,C} vector.
    localparam int FLAG_O = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } ctx_state_t;

endpackage

// File: rtl/lifo_regfile.sv
// DEPTH x FLAG_W register array backing the flag-context LIFO.
// Latency: a write lands on the next clock edge; the read port is combinational.
// Backpressure: none; the caller decides when a write is legal.
// Ports: clk/rst_n (async active-low clear of every entry), wr_en/wr_addr/wr_data
// for the write port, rd_addr/rd_data for the combinational read-top port.
module lifo_regfile #(
    parameter int DEPTH  = 4,
    parameter int FLAG_W = cpu_pkg::FLAG_W,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [FLAG_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [FLAG_W-1:0] rd_data
);

    logic [FLAG_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so every rd_addr value names a real entry.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/flags_ctx_stack.sv
// Saves ALU flags {O,S,Z,C} on trap entry and restores them on rfe.
// Latency: a pop drives flags_we/flags_restore the cycle after pop_req is accepted.
// Backpressure: flags_we holds until a non-bubble enabled cycle; pop_ready=0 meanwhile.
// Ports: clk, rst_n (async active-low), clk_en (global stall), bubble (ALU ignores
// this slot), flags_in/push (save), pop_req/pop_ready (restore handshake),
// flags_restore/flags_we (ALU restore port), depth/top_flags (inspection),
// ovf_err/unf_err (sticky errors) and err_clr.
module flags_ctx_stack #(
    parameter int DEPTH  = 4,
    parameter int FLAG_W = cpu_pkg::FLAG_W,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clk_en,
    input  logic                       bubble,
    input  logic [FLAG_W-1:0]          flags_in,
    input  logic                       push,
    input  logic                       pop_req,
    output logic                       pop_ready,
    output logic [DATA_W-1:0]          flags_restore,
    output logic                       flags_we,
    output logic [$clog2(DEPTH):0]     depth,
    output logic [FLAG_W-1:0]          top_flags,
    output logic                       ovf_err,
    output logic                       unf_err,
    input  logic                       err_clr
);

    import cpu_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;
    localparam logic [DW-1:0] DEPTH_V = DW'(DEPTH);

    ctx_state_t        state_q, state_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic [DATA_W-1:0] restore_q, restore_d;
    logic              ovf_q, unf_q;

    logic              empty, full;
    logic [DW-1:0]     depth_m1;
    logic [AW-1:0]     top_idx;
    logic [FLAG_W-1:0] top_raw;
    logic              pop_go;

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic              ovf_set, unf_set;

    assign empty    = (depth_q == '0);
    assign full     = (depth_q == DEPTH_V);
    assign depth_m1 = depth_q - DW'(1);
    assign top_idx  = depth_m1[AW-1:0];

    // A pop is only taken from IDLE with something on the stack.
    assign pop_go = (state_q == ST_IDLE) && pop_req && !empty;

    lifo_regfile #(
        .DEPTH  (DEPTH),
        .FLAG_W (FLAG_W),
        .AW     (AW)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en && clk_en),
        .wr_addr (wr_addr),
        .wr_data (flags_in),
        .rd_addr (top_idx),
        .rd_data (top_raw)
    );

    always_comb begin
        state_d   = state_q;
        depth_d   = depth_q;
        restore_d = restore_q;
        wr_en     = 1'b0;
        wr_addr   = depth_q[AW-1:0];
        ovf_set   = 1'b0;
        unf_set   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pop_req) begin
                    if (empty) begin
                        unf_set = 1'b1;
                    end else begin
                        state_d                = ST_PEND;
                        restore_d              = '0;
                        restore_d[FLAG_W-1:0]  = top_raw;
                    end
                end
            end
            ST_PEND: begin
                // The ALU consumes the restore on the first non-bubble cycle;
                // clk_en gating happens at the register.
                if (!bubble) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (push) begin
            if (pop_go) begin
                // Swap: old top leaves via flags_restore, new flags take its slot.
                wr_en   = 1'b1;
                wr_addr = top_idx;
            end else if (full) begin
                ovf_set = 1'b1;
            end else begin
                wr_en   = 1'b1;
                depth_d = depth_q + DW'(1);
            end
        end else if (pop_go) begin
            depth_d = depth_m1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            depth_q   <= '0;
            restore_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else if (clk_en) begin
            state_q   <= state_d;
            depth_q   <= depth_d;
            restore_q <= restore_d;
            // A new error event outranks a simultaneous clear.
            ovf_q     <= ovf_set | (ovf_q & ~err_clr);
            unf_q     <= unf_set | (unf_q & ~err_clr);
        end
    end

    assign pop_ready     = (state_q == ST_IDLE);
    assign flags_we      = (state_q == ST_PEND);
    assign flags_restore = restore_q;
    assign depth         = depth_q;
    assign top_flags     = empty ? '0 : top_raw;
    assign ovf_err       = ovf_q;
    assign unf_err       = unf_q;

endmodule

// File: tb/tb_flags_ctx_stack.sv
// Directed bench for flags_ctx_stack with a model stack and a restore scoreboard.
// Expected restore values are queued when a pop is driven and checked when
// flags_we is observed.
module tb_flags_ctx_stack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clk_en = 1'b1;
    logic        bubble = 1'b0;
    logic [3:0]  flags_in = '0;
    logic        push = 1'b0;
    logic        pop_req = 1'b0;
    logic        pop_ready;
    logic [31:0] flags_restore;
    logic        flags_we;
    logic [2:0]  depth;
    logic [3:0]  top_flags;
    logic        ovf_err;
    logic        unf_err;
    logic        err_clr = 1'b0;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [3:0]  mst[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    flags_ctx_stack #(.DEPTH(4), .FLAG_W(4), .DATA_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_en        (clk_en),
        .bubble        (bubble),
        .flags_in      (flags_in),
        .push          (push),
        .pop_req       (pop_req),
        .pop_ready     (pop_ready),
        .flags_restore (flags_restore),
        .flags_we      (flags_we),
        .depth         (depth),
        .top_flags     (top_flags),
        .ovf_err       (ovf_err),
        .unf_err       (unf_err),
        .err_clr       (err_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_v(input logic [3:0] v);
        push = 1'b1;
        flags_in = v;
        tick();
        push = 1'b0;
        if (mst.size() < 4) mst.push_back(v);
    endtask

    task automatic pop_issue();
        pop_req = 1'b1;
        if (mst.size() > 0) begin
            exp_q.push_back(32'(mst[$]));
            void'(mst.pop_back());
        end
        tick();
        pop_req = 1'b0;
    endtask

    // Compare the restore the DUT is presenting against the oldest queued expectation.
    task automatic check_restore(input string tag);
        logic [31:0] e;
        chk({tag, "_we"}, 32'(flags_we), 32'd1);
        if (exp_q.size() == 0) begin
            total++;
            failed++;
            $error("FAIL %s_sb observed=restore expected=none_queued", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, flags_restore, e);
        end
    endtask

    initial begin
        int highs;

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_we", 32'(flags_we), 32'd0);
        chk("rst_restore", flags_restore, 32'd0);
        chk("rst_pop_ready", 32'(pop_ready), 32'd1);
        chk("rst_top", 32'(top_flags), 32'd0);
        chk("rst_errs", 32'({ovf_err, unf_err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic push/pop
        push_v(4'b1010);
        chk("t1_depth", 32'(depth), 32'(mst.size()));
        chk("t1_top", 32'(top_flags), 32'hA);
        pop_issue();
        check_restore("t1");
        chk("t1_depth_after", 32'(depth), 32'd0);
        chk("t1_ready_pend", 32'(pop_ready), 32'd0);
        tick();
        chk("t1_we_drop", 32'(flags_we), 32'd0);
        chk("t1_ready_idle", 32'(pop_ready), 32'd1);

        // Restore held through bubbles
        push_v(4'h7);
        pop_issue();
        check_restore("t2");
        highs = flags_we ? 1 : 0;
        bubble = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (flags_we) highs++;
            chk("t2_restore_hold", flags_restore, 32'h7);
        end
        bubble = 1'b0;
        tick();
        chk("t2_we_cycles", 32'(highs), 32'd4);
        chk("t2_we_drop", 32'(flags_we), 32'd0);

        // Restore held through clock-enable stalls
        push_v(4'h3);
        pop_issue();
        check_restore("t2b");
        clk_en = 1'b0;
        tick();
        tick();
        chk("t2b_we_stall", 32'(flags_we), 32'd1);
        clk_en = 1'b1;
        tick();
        chk("t2b_we_drop", 32'(flags_we), 32'd0);

        // Fill, overflow, then drain in LIFO order
        push_v(4'h1);
        push_v(4'h2);
        push_v(4'h3);
        push_v(4'h4);
        push_v(4'hF);
        chk("t3_depth_full", 32'(depth), 32'd4);
        chk("t3_ovf", 32'(ovf_err), 32'd1);
        chk("t3_top", 32'(top_flags), 32'h4);
        for (int i = 0; i < 4; i++) begin
            pop_issue();
            check_restore("t3_pop");
            tick();
        end
        chk("t3_depth_empty", 32'(depth), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_ovf_clr", 32'(ovf_err), 32'd0);

        // Underflow
        pop_issue();
        chk("t4_unf", 32'(unf_err), 32'd1);
        chk("t4_we", 32'(flags_we), 32'd0);
        chk("t4_ready", 32'(pop_ready), 32'd1);
        pop_req = 1'b1;
        err_clr = 1'b1;
        tick();
        pop_req = 1'b0;
        chk("t4_set_wins", 32'(unf_err), 32'd1);
        tick();
        err_clr = 1'b0;
        chk("t4_unf_clr", 32'(unf_err), 32'd0);

        // Simultaneous push and pop swaps the top
        push_v(4'h5);
        push_v(4'h6);
        push = 1'b1;
        pop_req = 1'b1;
        flags_in = 4'h9;
        exp_q.push_back(32'(mst[$]));
        mst[mst.size() - 1] = 4'h9;
        tick();
        push = 1'b0;
        pop_req = 1'b0;
        check_restore("t5");
        chk("t5_depth", 32'(depth), 32'd2);
        chk("t5_top", 32'(top_flags), 32'h9);

        // Trap landing during the restore window
        bubble = 1'b1;
        push_v(4'hC);
        chk("t5_push_pend_depth", 32'(depth), 32'(mst.size()));
        chk("t5_push_pend_restore", flags_restore, 32'h6);
        chk("t5_push_pend_we", 32'(flags_we), 32'd1);
        bubble = 1'b0;
        tick();
        chk("t5_we_drop", 32'(flags_we), 32'd0);

        // Asynchronous reset while a restore is pending and stalled
        pop_issue();
        check_restore("t6");
        clk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_we_async", 32'(flags_we), 32'd0);
        chk("t6_depth_async", 32'(depth), 32'd0);
        chk("t6_top_async", 32'(top_flags), 32'd0);
        mst.delete();
        @(negedge clk);
        rst_n = 1'b1;
        clk_en = 1'b1;

        // Push and pop together on an empty stack: push only, plus underflow
        push = 1'b1;
        pop_req = 1'b1;
        flags_in = 4'hB;
        tick();
        push = 1'b0;
        pop_req = 1'b0;
        chk("t7_depth", 32'(depth), 32'd1);
        chk("t7_unf", 32'(unf_err), 32'd1);
        chk("t7_we", 32'(flags_we), 32'd0);
        chk("t7_top", 32'(top_flags), 32'hB);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
